// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 mux (tree of three 2:1 muxes).
// Grant, select and valid are registered. y is decoded from those registers
// and follows the data inputs combinationally. An owner's tenure is capped at
// MAX_HOLD cycles while another requester is waiting.
module rr_mux4_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  // Registered state
  state_t     state_r;
  logic [1:0] owner_r;
  logic [1:0] last_r;
  logic [3:0] hold_cnt_r;
  logic [3:0] gnt_r;
  logic [1:0] sel_r;
  logic       valid_r;

  // Next-state values
  state_t     state_s;
  logic [1:0] owner_s;
  logic [1:0] last_s;
  logic [3:0] hold_cnt_s;
  logic [3:0] gnt_s;
  logic [1:0] sel_s;
  logic       valid_s;

  logic [3:0] others_s;
  logic [1:0] pick_s;
  logic [1:0] rot_pick_s;

  // Index to one-hot decode.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: candidates are scanned from last+1 upward (mod 4),
  // with last itself considered only after the other three.
  function automatic logic [1:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Candidate winners: fresh pick from all requests, and rotation pick that
  // excludes the current owner.
  always_comb begin
    others_s   = req & ~onehot4(owner_r);
    pick_s     = rr_pick(req, last_r);
    rot_pick_s = rr_pick(others_s, owner_r);
  end

  // Next-state and tenure bookkeeping.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    last_s     = last_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          state_s    = GRANT;
          owner_s    = pick_s;
          last_s     = pick_s;
          hold_cnt_s = 4'd1;
        end else begin
          state_s    = IDLE;
        end
      end
      GRANT: begin
        if (!req[owner_r]) begin
          if (others_s != 4'b0000) begin
            // Hand over at the same edge, no idle bubble.
            owner_s    = rot_pick_s;
            last_s     = rot_pick_s;
            hold_cnt_s = 4'd1;
          end else begin
            state_s    = IDLE;
            owner_s    = 2'b00;
            hold_cnt_s = 4'd0;
          end
        end else if (hold_cnt_r < MAX_HOLD_C) begin
          hold_cnt_s = hold_cnt_r + 4'd1;
        end else if (others_s != 4'b0000) begin
          // Tenure exhausted with someone waiting: force rotation.
          owner_s    = rot_pick_s;
          last_s     = rot_pick_s;
          hold_cnt_s = 4'd1;
        end else begin
          // Nobody waiting: keep the grant, counter saturates.
          hold_cnt_s = MAX_HOLD_C;
        end
      end
      default: begin
        state_s    = IDLE;
        owner_s    = 2'b00;
        last_s     = 2'd3;
        hold_cnt_s = 4'd0;
      end
    endcase
  end

  // Output decode of the next state; registered below so outputs are glitch-free.
  always_comb begin
    if (state_s == GRANT) begin
      gnt_s   = onehot4(owner_s);
      sel_s   = owner_s;
      valid_s = 1'b1;
    end else begin
      gnt_s   = 4'b0000;
      sel_s   = 2'b00;
      valid_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset; last=3 gives input 0
  // first priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= 2'b00;
      last_r     <= 2'd3;
      hold_cnt_r <= 4'd0;
      gnt_r      <= 4'b0000;
      sel_r      <= 2'b00;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      last_r     <= last_s;
      hold_cnt_r <= hold_cnt_s;
      gnt_r      <= gnt_s;
      sel_r      <= sel_s;
      valid_r    <= valid_s;
    end
  end

  // Mux tree: stage 1 on S0 (i0/i1, i2/i3), stage 2 on S1; zero when idle.
  logic [WIDTH-1:0] stage_lo_s;
  logic [WIDTH-1:0] stage_hi_s;

  always_comb begin
    if (sel_r[0]) begin
      stage_lo_s = d1;
      stage_hi_s = d3;
    end else begin
      stage_lo_s = d0;
      stage_hi_s = d2;
    end
    if (!valid_r) begin
      y = '0;
    end else if (sel_r[1]) begin
      y = stage_hi_s;
    end else begin
      y = stage_lo_s;
    end
  end

  assign gnt   = gnt_r;
  assign sel   = sel_r;
  assign valid = valid_r;

endmodule
